// File: rtl/timing_generator.sv
// timing_generator: M6502 T-state sequencer and instruction register.
// Walks a one-hot T-state vector, fetches the next opcode whenever decode
// flags the current cycle as the instruction's last, stalls on rdy = 0,
// and traps into a sticky jam state if the sequence runs past T7.
module timing_generator #(
  parameter logic [7:0] RESET_OPCODE = 8'hea,
  parameter int         COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rdy,
  input  logic [7:0]             data_in,
  input  logic                   timing_reset,
  output logic [7:0]             timing,
  output logic [7:0]             opcode,
  output logic                   sync,
  output logic                   jam,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  // Reset parks the sequencer in T0 with a NOP in the IR so that decode
  // requests the first real fetch on the cycle after release.
  localparam logic [7:0] T0_STATE = 8'b0000_0001;
  localparam logic [7:0] T1_STATE = 8'b0000_0010;

  logic [7:0]             timing_q, timing_d;
  logic [7:0]             opcode_q, opcode_d;
  logic                   sync_q, sync_d;
  logic                   jam_q, jam_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Next-state: jam freezes everything, rdy = 0 stalls, a fetch restarts at
  // T1, running off the end of T7 jams, otherwise step to the next T-state.
  always_comb begin
    timing_d = timing_q;
    opcode_d = opcode_q;
    sync_d   = sync_q;
    jam_d    = jam_q;
    count_d  = count_q;
    if (!jam_q && rdy) begin
      if (timing_reset) begin
        // timing_reset wins over the shift in every T-state, T7 included.
        opcode_d = data_in;
        timing_d = T1_STATE;
        sync_d   = 1'b1;
        count_d  = count_q + COUNT_WIDTH'(1);
      end else if (timing_q[7]) begin
        // No way forward from T7: all-zero timing marks the trap.
        timing_d = '0;
        jam_d    = 1'b1;
        sync_d   = 1'b0;
      end else begin
        timing_d = {timing_q[6:0], 1'b0};
        sync_d   = 1'b0;
      end
    end
  end

  // State register with asynchronous, active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timing_q <= T0_STATE;
      opcode_q <= RESET_OPCODE;
      sync_q   <= 1'b0;
      jam_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      timing_q <= timing_d;
      opcode_q <= opcode_d;
      sync_q   <= sync_d;
      jam_q    <= jam_d;
      count_q  <= count_d;
    end
  end

  // Every output comes straight from a register; no input-to-output paths.
  assign timing      = timing_q;
  assign opcode      = opcode_q;
  assign sync        = sync_q;
  assign jam         = jam_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_timing_generator.sv
// Bench for timing_generator: a stage-number model plus a small decode model
// (NOP, LDA #, JMP abs) drive and check two instances (16- and 4-bit counters).
module tb_timing_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  data_in = 8'hea;
  logic        timing_reset = 1'b0;

  logic [7:0]  timing, opcode, timing4, opcode4;
  logic        sync, jam, sync4, jam4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  timing_generator #(.RESET_OPCODE(8'hea), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .rdy(rdy), .data_in(data_in),
    .timing_reset(timing_reset), .timing(timing), .opcode(opcode),
    .sync(sync), .jam(jam), .instr_count(cnt16));

  timing_generator #(.RESET_OPCODE(8'hea), .COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .rdy(rdy), .data_in(data_in),
    .timing_reset(timing_reset), .timing(timing4), .opcode(opcode4),
    .sync(sync4), .jam(jam4), .instr_count(cnt4));

  initial forever #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: T-state as a plain stage number 0..7, jam flag.
  bit          m_jam;
  int          m_stage;
  logic [7:0]  m_op;
  bit          m_sync;
  logic [31:0] m_cnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_jam <= 1'b0; m_stage <= 0; m_op <= 8'hea; m_sync <= 1'b0; m_cnt <= 0;
    end else if (m_jam || !rdy) begin
      m_jam <= m_jam;
    end else if (timing_reset) begin
      m_op <= data_in; m_stage <= 1; m_sync <= 1'b1; m_cnt <= m_cnt + 1;
    end else if (m_stage == 7) begin
      m_jam <= 1'b1; m_sync <= 1'b0;
    end else begin
      m_stage <= m_stage + 1; m_sync <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_timing();
    return m_jam ? 32'd0 : (32'd1 << m_stage);
  endfunction

  // Compare every cycle, away from the rising edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("timing",  32'(timing),  exp_timing());
      check("opcode",  32'(opcode),  32'(m_op));
      check("sync",    32'(sync),    32'(m_sync));
      check("jam",     32'(jam),     32'(m_jam));
      check("count16", 32'(cnt16),   32'(m_cnt[15:0]));
      check("count4",  32'(cnt4),    32'(m_cnt[3:0]));
      check("timing4", 32'(timing4), exp_timing());
      check("jam4",    32'(jam4),    32'(m_jam));
    end
  end

  // Stimulus: memory image, decode model, input modes.
  logic [7:0] prog [64];
  int  ptr = 0;
  int  tr_mode = 0;   // 0 decode, 1 force 1, 2 force 0, 3 random
  bit  rnd_rdy = 1'b0;
  bit  rnd_data = 1'b0;

  function automatic int op_len(input logic [7:0] op);
    case (op)
      8'ha9:   return 2;
      8'h4c:   return 3;
      default: return 1;
    endcase
  endfunction

  // Decode model: does the current cycle end the instruction in the IR?
  function automatic bit dec_last();
    if (m_jam) return 1'b0;
    if (m_stage == 0) return 1'b1;
    case (m_op)
      8'hea, 8'ha9: return m_stage == 1;
      8'h4c:        return m_stage == 2;
      default:      return m_stage >= 1 + int'(m_op % 7);
    endcase
  endfunction

  task automatic drive();
    logic [7:0] d;
    bit t;
    if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
    d = rnd_data ? 8'($urandom) : prog[ptr & 63];
    case (tr_mode)
      0:       t = dec_last();
      1:       t = 1'b1;
      2:       t = 1'b0;
      default: t = 1'($urandom_range(0, 1));
    endcase
    data_in = d;
    timing_reset = t;
    if (!m_jam && rdy && t && !reset) ptr = ptr + op_len(d);
  endtask

  task automatic cyc();
    @(negedge clock); #1;
    drive();
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    for (int i = 0; i < 64; i++) prog[i] = 8'hea;
    prog[0] = b0; prog[1] = b1; prog[2] = b2; prog[3] = b3; prog[4] = b4; prog[5] = b5;
    ptr = 0;
  endtask

  // Hold reset across a clock, then release at a falling edge: the
  // following cycle is cycle 0 (T0).
  task automatic restart();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0; rdy = 1'b1; tr_mode = 0; rnd_rdy = 1'b0; rnd_data = 1'b0;
    drive();
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    check("rst timing", 32'(timing), 32'h01);
    check("rst opcode", 32'(opcode), 32'hea);
    check("rst sync",   32'(sync),   32'h0);
    check("rst jam",    32'(jam),    32'h0);
    check("rst count",  32'(cnt16),  32'h0);

    // NOP stream: T0 once, then T1 every cycle with sync held high.
    load_prog(8'hea, 8'hea, 8'hea, 8'hea, 8'hea, 8'hea);
    restart();
    check("c0 timing", 32'(timing), 32'h01);
    check("c0 opcode", 32'(opcode), 32'hea);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("nop timing", 32'(timing), 32'h02);
      check("nop sync",   32'(sync),   32'h1);
      check("nop count",  32'(cnt16),  32'(k));
    end

    // LDA #, JMP abs, NOP.
    load_prog(8'ha9, 8'h55, 8'h4c, 8'h00, 8'h80, 8'hea);
    restart();
    cyc();
    check("lda op", 32'(opcode), 32'ha9); check("lda t", 32'(timing), 32'h02);
    check("lda sync", 32'(sync), 32'h1);  check("lda cnt", 32'(cnt16), 32'h1);
    cyc();
    check("jmp1 op", 32'(opcode), 32'h4c); check("jmp1 t", 32'(timing), 32'h02);
    check("jmp1 sync", 32'(sync), 32'h1);  check("jmp1 cnt", 32'(cnt16), 32'h2);
    cyc();
    check("jmp2 op", 32'(opcode), 32'h4c); check("jmp2 t", 32'(timing), 32'h04);
    check("jmp2 sync", 32'(sync), 32'h0);
    cyc();
    check("nop op", 32'(opcode), 32'hea); check("nop t", 32'(timing), 32'h02);
    check("nop sync", 32'(sync), 32'h1);  check("nop cnt", 32'(cnt16), 32'h3);

    // Stall at JMP T1 for three cycles with timing_reset forced high.
    load_prog(8'h4c, 8'h00, 8'h80, 8'hea, 8'hea, 8'hea);
    restart();
    cyc();
    rdy = 1'b0; tr_mode = 1; drive();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall t",   32'(timing), 32'h02);
      check("stall op",  32'(opcode), 32'h4c);
      check("stall cnt", 32'(cnt16),  32'h1);
    end
    rdy = 1'b1; tr_mode = 0; drive();
    cyc();
    check("unstall t", 32'(timing), 32'h04);
    check("unstall sync", 32'(sync), 32'h0);

    // Runaway sequence into jam; jam ignores timing_reset and rdy.
    load_prog(8'hea, 8'hea, 8'hea, 8'hea, 8'hea, 8'hea);
    restart();
    cyc();
    tr_mode = 2; drive();
    for (int s = 2; s <= 7; s++) begin
      cyc();
      check("walk t", 32'(timing), 32'd1 << s);
    end
    cyc();
    check("jam t", 32'(timing), 32'h0);
    check("jam flag", 32'(jam), 32'h1);
    tr_mode = 1; rnd_rdy = 1'b1; drive();
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("jammed t", 32'(timing), 32'h0);
      check("jammed op", 32'(opcode), 32'hea);
    end
    @(negedge clock); reset = 1'b1; #1;
    check("unjam t", 32'(timing), 32'h01);
    check("unjam flag", 32'(jam), 32'h0);

    // Asynchronous reset in the middle of JMP T2.
    load_prog(8'h4c, 8'h00, 8'h80, 8'hea, 8'hea, 8'hea);
    restart();
    cyc(); cyc();
    check("pre-async t", 32'(timing), 32'h04);
    #2 reset = 1'b1; #1;
    check("async t",    32'(timing), 32'h01);
    check("async op",   32'(opcode), 32'hea);
    check("async sync", 32'(sync),   32'h0);
    check("async cnt",  32'(cnt16),  32'h0);

    // Counter wrap on the 4-bit instance.
    load_prog(8'hea, 8'hea, 8'hea, 8'hea, 8'hea, 8'hea);
    restart();
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 15) check("cnt4 at 15", 32'(cnt4), 32'hf);
      if (k == 16) begin
        check("cnt4 wrap", 32'(cnt4), 32'h0);
        check("cnt16 at 16", 32'(cnt16), 32'h10);
        check("wrap t", 32'(timing4), 32'h02);
        check("wrap op", 32'(opcode4), 32'hea);
        check("wrap sync", 32'(sync4), 32'h1);
      end
    end

    // Random traffic: random data, mixed decode/random timing_reset,
    // random rdy, and occasional asynchronous reset pulses.
    restart();
    rnd_data = 1'b1; rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tr_mode = ($urandom_range(0, 3) == 0) ? 3 : 0;
      cyc();
      if (m_jam && $urandom_range(0, 2) == 0) begin
        #1 reset = 1'b1; #1 reset = 1'b0;
        drive();
      end else if ($urandom_range(0, 60) == 0) begin
        #2 reset = 1'b1; #1 reset = 1'b0;
        drive();
      end
    end

    @(negedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
